// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: steps each instruction through fetch/decode/execute/memory/writeback.
// Optional retired-instruction counter enabled by defining CPU_CTRL_INSTRET_EN.
module cpu_control_fsm (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] Instr,
    input  logic [3:0]  Status,
    input  logic        MemReady,
    output logic        PCSel,
    output logic        PCEn,
    output logic        EnWrite,
    output logic        ALUsrc,
    output logic        WB,
    output logic        MRW,
    output logic        MemReq,
    output logic [1:0]  IMMXSel,
    output logic        Trap,
    output logic [2:0]  State,
    output logic [31:0] InstRet
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WBACK  = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_ralu, is_ialu, is_load, is_store, is_branch, is_beq, is_bne, legal;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_ralu   = (opcode == 7'b0110011);
    assign is_ialu   = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_beq    = is_branch && (funct3 == 3'b000);
    assign is_bne    = is_branch && (funct3 == 3'b001);
    assign legal     = is_ralu || is_ialu || is_load || is_store || is_beq || is_bne;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        PCSel   = 1'b1;
        PCEn    = 1'b0;
        EnWrite = 1'b0;
        ALUsrc  = 1'b0;
        WB      = 1'b1;
        MRW     = 1'b0;
        MemReq  = 1'b0;
        IMMXSel = 2'b00;
        Trap    = 1'b0;

        // Operand selects set up in EXEC stay stable until the instruction retires
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WBACK) begin
            ALUsrc  = is_ialu || is_load || is_store;
            IMMXSel = is_store ? 2'b01 : (is_branch ? 2'b10 : 2'b00);
        end

        case (state_q)
            S_FETCH: begin
                if (Run) begin
                    state_d = S_DECODE;
                    ir_d    = Instr;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WBACK;
            S_MEM: begin
                MemReq = 1'b1;
                MRW    = is_store;
                if (MemReady) state_d = S_WBACK;
            end
            S_WBACK: begin
                PCEn    = 1'b1;
                EnWrite = is_ralu || is_ialu || is_load;
                WB      = !is_load;
                PCSel   = !((is_beq && Status[0]) || (is_bne && !Status[0]));
                state_d = S_FETCH;
            end
            S_TRAP: Trap = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    assign State = state_q;

`ifdef CPU_CTRL_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    assign instret_d = (state_q == S_WBACK) ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign InstRet = instret_q;
`else
    assign InstRet = '0;
`endif

endmodule
